stats_window_sequencer: RTL and testbench

Front-end controller for the moving-statistics datapath. It accepts market samples over a valid/ready handshake and keeps the last WINDOW_SIZE samples in a circular buffer. For each sample it issues one update (incoming, outgoing) to the accumulators, then sequences the iterative square-root unit through its start/busy/valid handshake. A watchdog covers the square-root unit, and a flush path clears the window.

---
 rtl/stats_pkg.sv | 25 ++
 rtl/sample_window_buffer.sv | 27 ++
 rtl/stats_window_sequencer.sv | 139 +++++++++++++
 tb/tb_stats_window_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stats_pkg.sv
// Shared types and width helpers for the moving-statistics front end.
package stats_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UPDATE,
    SQRT_REQ,
    SQRT_WAIT,
    DONE
  } state_t;

  function automatic int ptr_w(input int window_size);
    return $clog2(window_size);
  endfunction

  function automatic int cnt_w(input int window_size);
    return ptr_w(window_size) + 1;
  endfunction

  // Watchdog must be able to hold the full timeout value itself
  function automatic int wd_w(input int sqrt_timeout);
    return $clog2(sqrt_timeout + 1);
  endfunction

endpackage

// File: rtl/sample_window_buffer.sv
// Circular sample store: synchronous write, combinational read of the addressed slot,
// so the value being overwritten is visible in the same cycle as the write.
module sample_window_buffer
  import stats_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int WINDOW_SIZE = 64,
  localparam int PTR_W      = ptr_w(WINDOW_SIZE)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [WINDOW_SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/stats_window_sequencer.sv
// Accepts samples into a sliding window, issues one accumulator update per sample and
// sequences the square-root unit, guarded by a watchdog; flush empties the window.
module stats_window_sequencer
  import stats_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int WINDOW_SIZE  = 64,
  parameter int SQRT_TIMEOUT = 64
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_sample_valid,
  input  logic [DATA_WIDTH-1:0]        i_sample,
  output logic                         o_sample_ready,
  input  logic                         i_flush,
  output logic                         o_stats_update,
  output logic [DATA_WIDTH-1:0]        o_stats_incoming,
  output logic [DATA_WIDTH-1:0]        o_stats_outgoing,
  output logic                         o_stats_clear,
  output logic                         o_sqrt_start,
  input  logic                         i_sqrt_busy,
  input  logic                         i_sqrt_valid,
  output logic [$clog2(WINDOW_SIZE):0] o_fill_count,
  output logic                         o_window_full,
  output logic                         o_result_valid,
  output logic                         o_timeout_error
);

  localparam int PTR_W = ptr_w(WINDOW_SIZE);
  localparam int CNT_W = cnt_w(WINDOW_SIZE);
  localparam int WD_W  = wd_w(SQRT_TIMEOUT);

  state_t                state, state_next;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      fill_count;
  logic [WD_W-1:0]       watchdog;
  logic [DATA_WIDTH-1:0] incoming_q, outgoing_q, rd_data;
  logic                  clear_q, error_q;
  logic                  accept, flush_go, window_full, in_sqrt, next_in_sqrt;
  logic                  timeout_hit, timeout_fire;

  assign flush_go     = (state == IDLE) && i_flush;
  assign accept       = (state == IDLE) && !i_flush && i_sample_valid;
  assign window_full  = (fill_count == CNT_W'(WINDOW_SIZE));
  assign in_sqrt      = (state == SQRT_REQ) || (state == SQRT_WAIT);
  assign next_in_sqrt = (state_next == SQRT_REQ) || (state_next == SQRT_WAIT);
  assign timeout_hit  = in_sqrt && (watchdog == WD_W'(SQRT_TIMEOUT - 1));

  sample_window_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .WINDOW_SIZE(WINDOW_SIZE)
  ) u_buffer (
    .clk    (i_clk),
    .wr_en  (accept),
    .addr   (wr_ptr),
    .wr_data(i_sample),
    .rd_data(rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A result arriving on the last watchdog cycle still counts as a success
  always_comb begin
    state_next   = state;
    o_sqrt_start = 1'b0;
    timeout_fire = 1'b0;
    case (state)
      IDLE:      if (accept) state_next = UPDATE;
      UPDATE:    state_next = SQRT_REQ;
      SQRT_REQ: begin
        if (timeout_hit) begin
          timeout_fire = 1'b1;
          state_next   = IDLE;
        end else if (!i_sqrt_busy) begin
          o_sqrt_start = 1'b1;
          state_next   = SQRT_WAIT;
        end
      end
      SQRT_WAIT: begin
        if (i_sqrt_valid) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          timeout_fire = 1'b1;
          state_next   = IDLE;
        end
      end
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outgoing is read from the slot about to be overwritten, before the write lands
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      fill_count <= '0;
      watchdog   <= '0;
      incoming_q <= '0;
      outgoing_q <= '0;
      clear_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      clear_q <= flush_go;
      if (flush_go) begin
        wr_ptr     <= '0;
        fill_count <= '0;
        error_q    <= 1'b0;
      end else if (accept) begin
        incoming_q <= i_sample;
        outgoing_q <= window_full ? rd_data : '0;
        wr_ptr     <= wr_ptr + PTR_W'(1);
        if (!window_full) begin
          fill_count <= fill_count + CNT_W'(1);
        end
      end
      if (timeout_fire) begin
        error_q <= 1'b1;
      end
      watchdog <= (in_sqrt && next_in_sqrt) ? watchdog + WD_W'(1) : '0;
    end
  end

  assign o_sample_ready   = (state == IDLE) && !i_flush;
  assign o_stats_update   = (state == UPDATE);
  assign o_result_valid   = (state == DONE);
  assign o_stats_incoming = incoming_q;
  assign o_stats_outgoing = outgoing_q;
  assign o_stats_clear    = clear_q;
  assign o_fill_count     = fill_count;
  assign o_window_full    = window_full;
  assign o_timeout_error  = error_q;

endmodule

// File: tb/tb_stats_window_sequencer.sv
// Scoreboard bench: stimulus queues expected updates/results, a negedge monitor checks them.
module tb_stats_window_sequencer;

  localparam int DW = 32;
  localparam int WS = 4;
  localparam int TO = 12;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_sample_valid;
  logic [DW-1:0] i_sample;
  logic          o_sample_ready;
  logic          i_flush;
  logic          o_stats_update;
  logic [DW-1:0] o_stats_incoming;
  logic [DW-1:0] o_stats_outgoing;
  logic          o_stats_clear;
  logic          o_sqrt_start;
  logic          i_sqrt_busy;
  logic          i_sqrt_valid;
  logic [2:0]    o_fill_count;
  logic          o_window_full;
  logic          o_result_valid;
  logic          o_timeout_error;

  stats_window_sequencer #(
    .DATA_WIDTH  (DW),
    .WINDOW_SIZE (WS),
    .SQRT_TIMEOUT(TO)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_sample_valid  (i_sample_valid),
    .i_sample        (i_sample),
    .o_sample_ready  (o_sample_ready),
    .i_flush         (i_flush),
    .o_stats_update  (o_stats_update),
    .o_stats_incoming(o_stats_incoming),
    .o_stats_outgoing(o_stats_outgoing),
    .o_stats_clear   (o_stats_clear),
    .o_sqrt_start    (o_sqrt_start),
    .i_sqrt_busy     (i_sqrt_busy),
    .i_sqrt_valid    (i_sqrt_valid),
    .o_fill_count    (o_fill_count),
    .o_window_full   (o_window_full),
    .o_result_valid  (o_result_valid),
    .o_timeout_error (o_timeout_error)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] inc;
    logic [DW-1:0] out;
    int            fill;
  } upd_t;

  upd_t upd_q[$];
  int   res_q[$];

  int checks = 0;
  int failures = 0;

  int last_accept = -1, start_count = 0, last_start_cyc = -1;
  int res_count = 0, last_res_cyc = -1, clear_count = 0, last_clear_cyc = -1;
  int err_rise_cyc = -1;
  bit err_prev = 1'b0;

  int sqrt_lat = 0;
  bit force_busy = 1'b0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops scoreboard entries whenever the DUT presents an update or result
  initial begin
    upd_t e;
    int   exp_cyc;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        err_prev = 1'b0;
      end else begin
        if (i_sample_valid && o_sample_ready) last_accept = cyc + 1;
        if (o_stats_update) begin
          if (upd_q.size() == 0) begin
            checkOutput("unexpected_update", 1, 0);
          end else begin
            e = upd_q.pop_front();
            checkOutput("upd_incoming", o_stats_incoming, e.inc);
            checkOutput("upd_outgoing", o_stats_outgoing, e.out);
            checkOutput("upd_fill", o_fill_count, e.fill);
            checkOutput("upd_full", o_window_full, (e.fill == WS) ? 1 : 0);
            checkOutput("upd_cycle", cyc, last_accept);
          end
          checkOutput("upd_start_overlap", o_sqrt_start, 0);
        end
        if (o_sqrt_start) begin
          start_count++;
          last_start_cyc = cyc;
        end
        if (o_result_valid) begin
          res_count++;
          last_res_cyc = cyc;
          if (res_q.size() == 0) begin
            checkOutput("unexpected_result", 1, 0);
          end else begin
            exp_cyc = res_q.pop_front();
            checkOutput("result_cycle", cyc, exp_cyc);
          end
        end
        if (o_stats_clear) begin
          clear_count++;
          last_clear_cyc = cyc;
        end
        if (o_timeout_error && !err_prev) err_rise_cyc = cyc;
        err_prev = o_timeout_error;
      end
    end
  end

  // Square-root unit model: result valid sqrt_lat cycles after start; 0 means never
  initial begin
    int cd = 0;
    int seen = 0;
    i_sqrt_valid = 1'b0;
    i_sqrt_busy  = 1'b0;
    forever begin
      @(posedge i_clk);
      #2;
      i_sqrt_valid = 1'b0;
      if (start_count != seen) begin
        seen = start_count;
        if (sqrt_lat > 0) begin
          cd = sqrt_lat - 1;
          if (cd == 0) i_sqrt_valid = 1'b1;
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) i_sqrt_valid = 1'b1;
      end
      i_sqrt_busy = force_busy || (cd > 0);
    end
  end

  task automatic waitReady(input string name);
    int n = 0;
    while (!o_sample_ready && n < 200) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    if (!o_sample_ready) checkOutput({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic applyStimulus(input logic [DW-1:0] v, input logic [DW-1:0] exp_out,
                               input int exp_fill, input int lat, input int start_delay,
                               input bit exp_res, output int acc);
    upd_t e;
    sqrt_lat = lat;
    e.inc = v;
    e.out = exp_out;
    e.fill = exp_fill;
    waitReady("accept");
    upd_q.push_back(e);
    i_sample_valid = 1'b1;
    i_sample = v;
    @(posedge i_clk);
    #1;
    acc = cyc;
    i_sample_valid = 1'b0;
    if (exp_res) res_q.push_back(acc + 2 + start_delay + lat);
  endtask

  task automatic waitIdle(output int rdy);
    waitReady("idle");
    rdy = cyc;
    @(posedge i_clk);
    #1;
  endtask

  task automatic doFlush();
    int f, c0;
    waitReady("flush");
    c0 = clear_count;
    i_flush = 1'b1;
    i_sample_valid = 1'b1;
    i_sample = 9;
    #1;
    checkOutput("flush_ready_low", o_sample_ready, 0);
    @(posedge i_clk);
    #1;
    f = cyc;
    i_flush = 1'b0;
    i_sample_valid = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput("flush_clear_cycle", last_clear_cyc, f);
    checkOutput("flush_clear_count", clear_count, c0 + 1);
    checkOutput("flush_fill", o_fill_count, 0);
    checkOutput("flush_error", o_timeout_error, 0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int a, rdy, s0, r0, c0;
    int fill_out[6]  = '{0, 0, 0, 0, 1, 2};
    int fill_cnt[6]  = '{1, 2, 3, 4, 4, 4};
    i_reset = 1'b1;
    i_sample_valid = 1'b0;
    i_sample = '0;
    i_flush = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("rst_ready", o_sample_ready, 1);
    checkOutput("rst_fill", o_fill_count, 0);
    checkOutput("rst_full", o_window_full, 0);
    checkOutput("rst_error", o_timeout_error, 0);
    checkOutput("rst_pulses", {o_stats_update, o_stats_clear, o_sqrt_start, o_result_valid}, 0);
    checkOutput("rst_outgoing", o_stats_outgoing, 0);
    i_reset = 1'b0;

    // Fill and wrap: window of four, oldest sample leaves once full
    for (int i = 0; i < 6; i++) begin
      applyStimulus(DW'(i + 1), DW'(fill_out[i]), fill_cnt[i], 3, 0, 1'b1, a);
      waitIdle(rdy);
      checkOutput("fill_count", o_fill_count, fill_cnt[i]);
    end

    // Latency with a 10-cycle square root
    s0 = start_count;
    r0 = res_count;
    applyStimulus(7, 3, 4, 10, 0, 1'b1, a);
    waitIdle(rdy);
    checkOutput("lat_start_cycle", last_start_cyc, a + 1);
    checkOutput("lat_start_count", start_count, s0 + 1);
    checkOutput("lat_result_count", res_count, r0 + 1);
    checkOutput("lat_ready_cycle", rdy, a + 13);

    // Busy backpressure holds start until busy drops
    force_busy = 1'b1;
    @(posedge i_clk);
    #1;
    s0 = start_count;
    applyStimulus(8, 4, 4, 3, 5, 1'b1, a);
    while (cyc < a + 4) begin @(posedge i_clk); #1; end
    checkOutput("busy_ready_low", o_sample_ready, 0);
    checkOutput("busy_no_start", start_count, s0);
    while (cyc < a + 6) begin @(posedge i_clk); #1; end
    force_busy = 1'b0;
    waitIdle(rdy);
    checkOutput("busy_start_cycle", last_start_cyc, a + 6);
    checkOutput("busy_start_count", start_count, s0 + 1);

    // Watchdog expiry with a square root that never answers
    r0 = res_count;
    applyStimulus(10, 5, 4, 0, 0, 1'b0, a);
    waitIdle(rdy);
    checkOutput("to_ready_cycle", rdy, a + 13);
    checkOutput("to_error_cycle", err_rise_cyc, a + 13);
    checkOutput("to_error", o_timeout_error, 1);
    checkOutput("to_no_result", res_count, r0);

    // Flush clears error and window; then refill three and flush again
    doFlush();
    applyStimulus(11, 0, 1, 3, 0, 1'b1, a);
    waitIdle(rdy);
    applyStimulus(12, 0, 2, 3, 0, 1'b1, a);
    waitIdle(rdy);
    applyStimulus(13, 0, 3, 3, 0, 1'b1, a);
    waitIdle(rdy);
    doFlush();
    applyStimulus(7, 0, 1, 3, 0, 1'b1, a);
    waitIdle(rdy);

    // Valid arriving on the final watchdog cycle wins
    applyStimulus(20, 0, 2, 11, 0, 1'b1, a);
    waitIdle(rdy);
    checkOutput("coin_result_cycle", last_res_cyc, a + 13);
    checkOutput("coin_no_error", o_timeout_error, 0);

    // Reset while waiting on the square root; its late valid must be ignored
    r0 = res_count;
    c0 = clear_count;
    applyStimulus(21, 0, 3, 10, 0, 1'b0, a);
    while (cyc < a + 4) begin @(posedge i_clk); #1; end
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("mid_rst_ready", o_sample_ready, 1);
    checkOutput("mid_rst_pulses", {o_stats_update, o_stats_clear, o_sqrt_start, o_result_valid}, 0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    while (cyc < a + 20) begin @(posedge i_clk); #1; end
    checkOutput("mid_rst_no_result", res_count, r0);
    checkOutput("mid_rst_no_clear", clear_count, c0);
    checkOutput("mid_rst_fill", o_fill_count, 0);
    checkOutput("mid_rst_ready_after", o_sample_ready, 1);
    checkOutput("mid_rst_error", o_timeout_error, 0);

    checkOutput("upd_queue_empty", upd_q.size(), 0);
    checkOutput("res_queue_empty", res_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
